mult_sched: RTL and testbench

MULT_SCHED -- requirements
Module: mult_sched

---
 rtl/mult_sched.sv | 125 ++++++++++++
 tb/tb_mult_sched.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_sched.sv
// Two-channel round-robin scheduler around a 6x6 shift-add multiplier (one partial product per clock).
// Optional build macro MULT_EARLY_EXIT_EN: leave RUN once no set multiplier bits remain above the current step.
module mult_sched (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  req,
    input  logic [5:0]  a0,
    input  logic [5:0]  b0,
    input  logic [5:0]  a1,
    input  logic [5:0]  b1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [11:0] product,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  a_q, a_d;
    logic [5:0]  b_q, b_d;
    logic [11:0] acc_q, acc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic [11:0] product_q, product_d;

    logic        sel;
    logic [7:0]  a_ext;
    logic [11:0] addend;
    logic [5:0]  remaining;

    // Simultaneous requests go to the channel that was not served last.
    assign sel       = (req == 2'b11) ? ~last_q : req[1];
    assign a_ext     = {2'b00, a_q};
    assign addend    = a_ext[cnt_q] ? ({6'b0, b_q} << cnt_q) : 12'd0;
    assign remaining = a_q >> (cnt_q + 3'd1);

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        last_d    = last_q;
        gnt_d     = 2'b00;
        done_d    = 2'b00;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    owner_d = sel;
                    a_d     = sel ? a1 : a0;
                    b_d     = sel ? b1 : b0;
                    acc_d   = 12'd0;
                    cnt_d   = 3'd0;
                    gnt_d   = sel ? 2'b10 : 2'b01;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = acc_q + addend;
                cnt_d = cnt_q + 3'd1;
`ifdef MULT_EARLY_EXIT_EN
                if (remaining == 6'd0) begin
                    state_d = DONE;
                end
`else
                if (cnt_q == 3'd5) begin
                    state_d = DONE;
                end
`endif
            end
            DONE: begin
                product_d = acc_q;
                done_d    = owner_q ? 2'b10 : 2'b01;
                last_d    = owner_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            a_q       <= 6'd0;
            b_q       <= 6'd0;
            acc_q     <= 12'd0;
            cnt_q     <= 3'd0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            product_q <= 12'd0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign product = product_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_mult_sched.sv
// Directed bench for mult_sched: expected (channel, product) pairs are queued at stimulus time and popped on done.
module tb_mult_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [5:0]  a0 = 6'd0, b0 = 6'd0, a1 = 6'd0, b1 = 6'd0;
    logic [1:0]  gnt, done;
    logic [11:0] product;
    logic        busy;

    int n_asserts = 0;
    int n_fails   = 0;
    logic [1:0] prev_gnt = 2'b00, prev_done = 2'b00;

    typedef struct {
        logic        ch;
        logic [11:0] prod;
    } job_t;
    job_t sb_q[$];

`ifdef MULT_EARLY_EXIT_EN
    localparam int SHORT_LAT = 2;
`else
    localparam int SHORT_LAT = 7;
`endif

    mult_sched dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (req),
        .a0      (a0),
        .b0      (b0),
        .a1      (a1),
        .b1      (b1),
        .gnt     (gnt),
        .done    (done),
        .product (product),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
        $display("check %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one edge and sample 1 time unit later; verify pulse invariants every cycle.
    task automatic step();
        logic ok;
        @(posedge clk);
        #1;
        ok = $onehot0(gnt) && $onehot0(done) && ((gnt & prev_gnt) == 2'b00)
             && ((done & prev_done) == 2'b00);
        check("pulse_invariant", {31'd0, ok}, 32'd1);
        prev_gnt  = gnt;
        prev_done = done;
    endtask

    task automatic push(input logic ch, input int p);
        job_t j;
        j.ch   = ch;
        j.prod = p[11:0];
        sb_q.push_back(j);
    endtask

    task automatic expect_gnt(input logic ch);
        step();
        check("gnt", {30'd0, gnt}, ch ? 32'd2 : 32'd1);
        check("busy_after_gnt", {31'd0, busy}, 32'd1);
    endtask

    // exp_cycles counts edges from the current sample point to the done pulse.
    task automatic wait_done(input int exp_cycles);
        int   n;
        logic stray_gnt;
        job_t j;
        n = 0;
        stray_gnt = 1'b0;
        while (n < 20) begin
            step();
            n++;
            if (done !== 2'b00) break;
            if (gnt !== 2'b00) stray_gnt = 1'b1;
        end
        check("done_latency", n, exp_cycles);
        check("no_gnt_while_busy", {31'd0, stray_gnt}, 32'd0);
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            j = sb_q.pop_front();
            check("done_channel", {30'd0, done}, j.ch ? 32'd2 : 32'd1);
            check("product", {20'd0, product}, {20'd0, j.prod});
        end
        check("busy_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 2'b00;
        #2;
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_done", {30'd0, done}, 32'd0);
        check("rst_product", {20'd0, product}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        #1;
        do_reset();

        // Scenario 1: lone request 6x5
        req = 2'b01; a0 = 6'd6; b0 = 6'd5;
        push(1'b0, 30);
        expect_gnt(1'b0);
        req = 2'b00;
        wait_done(7);

        // Scenario 2: both channels held from reset, max operands on ch0
        do_reset();
        req = 2'b11; a0 = 6'd63; b0 = 6'd63; a1 = 6'd3; b1 = 6'd7;
        push(1'b0, 3969);
        push(1'b1, 21);
        expect_gnt(1'b0);
        wait_done(7);
        expect_gnt(1'b1);
        req = 2'b00;
        wait_done(7);

        // Scenario 3: ch1 served last, both held -> 0,1,0,1
        req = 2'b11; a0 = 6'd2; b0 = 6'd3; a1 = 6'd4; b1 = 6'd5;
        for (int i = 0; i < 4; i++) begin
            push(i[0], i[0] ? 20 : 6);
        end
        for (int i = 0; i < 4; i++) begin
            expect_gnt(i[0]);
            if (i == 3) req = 2'b00;
            wait_done(7);
        end

        // Scenario 4: operands change mid-job, ch1 request arrives during RUN
        req = 2'b01; a0 = 6'd6; b0 = 6'd5;
        push(1'b0, 30);
        push(1'b1, 63);
        expect_gnt(1'b0);
        req = 2'b00;
        step();
        step();
        a0 = 6'd0; b0 = 6'd0;
        req = 2'b10; a1 = 6'd7; b1 = 6'd9;
        wait_done(5);
        expect_gnt(1'b1);
        req = 2'b00;
        wait_done(7);

        // Scenario 5: reset mid-job aborts without done
        req = 2'b01; a0 = 6'd5; b0 = 6'd5;
        expect_gnt(1'b0);
        req = 2'b00;
        step();
        step();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            check("no_done_after_abort", {30'd0, done}, 32'd0);
        end
        req = 2'b10; a1 = 6'd2; b1 = 6'd9;
        push(1'b1, 18);
        expect_gnt(1'b1);
        req = 2'b00;
        wait_done(7);

        // Scenario 6: early-exit candidates (full latency in the default build)
        req = 2'b01; a0 = 6'd1; b0 = 6'd63;
        push(1'b0, 63);
        expect_gnt(1'b0);
        req = 2'b00;
        wait_done(SHORT_LAT);
        req = 2'b01; a0 = 6'd0; b0 = 6'd63;
        push(1'b0, 0);
        step();
        check("gnt_idle_reentry", {30'd0, gnt}, 32'd1);
        req = 2'b00;
        wait_done(SHORT_LAT);
        req = 2'b01; a0 = 6'd32; b0 = 6'd63;
        push(1'b1 == 1'b0, 2016);
        expect_gnt(1'b0);
        req = 2'b00;
        wait_done(7);

        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
